// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage (master) and the multiply/divide unit (slave).
// EX asserts in_valid with an issue bit and holds operands while muldiv_stall is high.
interface muldiv_unit_if;
   logic        in_valid;
   logic [1:0]  mul_ctrl;
   logic [1:0]  div_ctrl;
   logic        mthi;
   logic        mtlo;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        ex_go;
   logic        cancel;
   logic        muldiv_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic [1:0]  state_dbg;

   modport master (
      output in_valid, mul_ctrl, div_ctrl, mthi, mtlo, src_a, src_b, ex_go, cancel,
      input  muldiv_stall, hi, lo, busy, state_dbg
   );

   modport slave (
      input  in_valid, mul_ctrl, div_ctrl, mthi, mtlo, src_a, src_b, ex_go, cancel,
      output muldiv_stall, hi, lo, busy, state_dbg
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers.
// Multiply takes one BUSY cycle; divide takes 32 restoring iterations plus a sign-fix/write cycle.
module muldiv_unit (
   input  logic          clk,
   input  logic          resetn,
   muldiv_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [5:0]  count;
   logic        op_div;
   logic        op_signed;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
      return (sgn && v[31]) ? (~v + 32'd1) : v;
   endfunction

   logic issue_req;
   logic issue;
   logic issue_div;
   logic issue_signed;
   logic div_last;

   assign issue_req    = bus.in_valid & (bus.div_ctrl[1] | bus.mul_ctrl[1]);
   assign issue        = issue_req & (state == IDLE) & ~bus.cancel;
   assign issue_div    = bus.div_ctrl[1];
   assign issue_signed = issue_div ? bus.div_ctrl[0] : bus.mul_ctrl[0];
   assign div_last     = (count == 6'd32);

   // One restoring step: quotient register shifts its MSB into the partial remainder.
   logic [31:0] b_mag;
   logic [32:0] shifted;
   logic        ge;
   logic [31:0] rem_step;
   logic [31:0] quo_step;

   assign b_mag    = abs32(b_reg, op_signed);
   assign shifted  = {rem, quo[31]};
   assign ge       = (shifted >= {1'b0, b_mag});
   assign rem_step = ge ? (shifted[31:0] - b_mag) : shifted[31:0];
   assign quo_step = {quo[30:0], ge};

   logic        q_neg;
   logic        r_neg;
   logic [31:0] q_fix;
   logic [31:0] r_fix;
   logic        div_zero;

   assign q_neg    = op_signed & (a_reg[31] ^ b_reg[31]);
   assign r_neg    = op_signed & a_reg[31];
   assign q_fix    = q_neg ? (~quo + 32'd1) : quo;
   assign r_fix    = r_neg ? (~rem + 32'd1) : rem;
   assign div_zero = (b_reg == 32'd0);

   logic [63:0] product;
   assign product = $signed({op_signed & a_reg[31], a_reg}) * $signed({op_signed & b_reg[31], b_reg});

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (bus.cancel) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (issue) state_nxt = BUSY;
            BUSY:    if (!op_div || div_last) state_nxt = DONE;
            DONE:    if (bus.ex_go) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count     <= 6'd0;
         op_div    <= 1'b0;
         op_signed <= 1'b0;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         quo       <= 32'd0;
         rem       <= 32'd0;
         hi_r      <= 32'd0;
         lo_r      <= 32'd0;
      end else if (bus.cancel) begin
         count     <= 6'd0;
         op_div    <= 1'b0;
         op_signed <= 1'b0;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         quo       <= 32'd0;
         rem       <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  op_div    <= issue_div;
                  op_signed <= issue_signed;
                  a_reg     <= bus.src_a;
                  b_reg     <= bus.src_b;
                  quo       <= abs32(bus.src_a, issue_signed);
                  rem       <= 32'd0;
                  count     <= 6'd0;
               end
               if (bus.in_valid && bus.mthi) hi_r <= bus.src_a;
               if (bus.in_valid && bus.mtlo) lo_r <= bus.src_a;
            end
            BUSY: begin
               if (!op_div) begin
                  hi_r <= product[63:32];
                  lo_r <= product[31:0];
               end else if (!div_last) begin
                  rem   <= rem_step;
                  quo   <= quo_step;
                  count <= count + 6'd1;
               end else if (div_zero) begin
                  hi_r <= a_reg;
                  lo_r <= 32'hFFFF_FFFF;
               end else begin
                  hi_r <= r_fix;
                  lo_r <= q_fix;
               end
            end
            default: count <= 6'd0;
         endcase
      end
   end

   assign bus.muldiv_stall = resetn & issue_req & (state != DONE) & ~bus.cancel;
   assign bus.busy         = (state != IDLE);
   assign bus.hi           = hi_r;
   assign bus.lo           = lo_r;
   assign bus.state_dbg    = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded bench for muldiv_unit: directed MULT/DIV corner cases, random ops,
// cancel and reset mid-divide, and holding in DONE.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   muldiv_unit_if bus ();
   muldiv_unit dut (.clk(clk), .resetn(resetn), .bus(bus));

   int vectors = 0;
   int miscompares = 0;
   logic [63:0] exp_q[$];
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.in_valid = 1'b0;
      bus.mul_ctrl = 2'b00;
      bus.div_ctrl = 2'b00;
      bus.mthi     = 1'b0;
      bus.mtlo     = 1'b0;
      bus.src_a    = 32'd0;
      bus.src_b    = 32'd0;
      bus.ex_go    = 1'b0;
      bus.cancel   = 1'b0;
   endtask

   function automatic logic [63:0] ref_result(input bit is_div, input bit sgn,
                                              input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      int sa;
      int sb;
      if (!is_div) begin
         ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
         eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
         return ea * eb;
      end
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (!sgn) return {a % b, a / b};
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a;
      sb = b;
      return {32'(sa % sb), 32'(sa / sb)};
   endfunction

   // Issue one op, measure stall/latency, compare HI/LO in DONE, optionally linger there.
   task automatic run_op(input bit is_div, input bit sgn, input bit both,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold, input string tag);
      int stall_cnt;
      int idx;
      bit done;
      logic [63:0] e;
      int lat;
      lat = is_div ? 34 : 2;
      exp_q.push_back(ref_result(is_div, sgn, a, b));
      idle_inputs();
      bus.in_valid = 1'b1;
      bus.src_a = a;
      bus.src_b = b;
      if (is_div || both) bus.div_ctrl = {1'b1, sgn};
      if (!is_div || both) bus.mul_ctrl = {1'b1, sgn};
      stall_cnt = 0;
      idx = 0;
      done = 1'b0;
      while (!done && idx < 60) begin
         @(negedge clk);
         if (bus.busy && !bus.muldiv_stall) done = 1'b1;
         else begin
            if (bus.muldiv_stall) stall_cnt++;
            idx++;
         end
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_lat"}, idx, lat);
      check({tag, "_stall"}, stall_cnt, lat);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      check(tag, {bus.hi, bus.lo}, e);
      hi_m = e[63:32];
      lo_m = e[31:0];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_stall"}, bus.muldiv_stall, 0);
         check({tag, "_hold_busy"}, bus.busy, 1);
         check({tag, "_hold_hilo"}, {bus.hi, bus.lo}, {hi_m, lo_m});
      end
      bus.ex_go = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      check({tag, "_idle"}, bus.busy, 0);
   endtask

   task automatic write_mt(input bit to_hi, input logic [31:0] v);
      idle_inputs();
      bus.in_valid = 1'b1;
      bus.src_a = v;
      if (to_hi) bus.mthi = 1'b1;
      else bus.mtlo = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      if (to_hi) hi_m = v;
      else lo_m = v;
      check(to_hi ? "mthi" : "mtlo", {bus.hi, bus.lo}, {hi_m, lo_m});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit r_div;
      bit r_sgn;
      logic [31:0] r_a;
      logic [31:0] r_b;
      idle_inputs();
      resetn = 1'b1;
      #2;
      resetn = 1'b0;
      bus.in_valid = 1'b1;
      bus.mul_ctrl = 2'b10;
      #1;
      check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
      check("rst_busy", bus.busy, 0);
      check("rst_stall", bus.muldiv_stall, 0);
      repeat (2) @(posedge clk);
      #1;
      idle_inputs();
      resetn = 1'b1;
      hi_m = 32'd0;
      lo_m = 32'd0;

      run_op(0, 1, 0, 32'hFFFF_FFFD, 32'd5, 0, "mult_neg");
      check("mult_neg_const", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op(0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
      check("multu_max_const", {hi_m, lo_m}, 64'hFFFF_FFFE_0000_0001);
      run_op(1, 1, 0, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
      check("div_neg_const", {hi_m, lo_m}, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op(1, 0, 0, 32'd100, 32'd7, 0, "divu");
      check("divu_const", {hi_m, lo_m}, {32'd2, 32'd14});
      run_op(1, 0, 0, 32'h1234_5678, 32'd0, 0, "divu_zero");
      run_op(1, 1, 0, 32'hFFFF_FFF6, 32'd0, 0, "div_zero_s");
      run_op(1, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run_op(1, 1, 0, 32'd7, 32'hFFFF_FFFE, 0, "div_pos_neg");
      run_op(1, 0, 1, 32'd1000, 32'd33, 0, "both_bits");

      for (int i = 0; i < 8; i++) begin
         r_div = 1'($urandom_range(0, 1));
         r_sgn = 1'($urandom_range(0, 1));
         r_a = $urandom();
         r_b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 40)) : $urandom();
         if ($urandom_range(0, 3) == 0) r_b = ~r_b + 32'd1;
         run_op(r_div, r_sgn, 0, r_a, r_b, 0, "rand");
      end

      // Cancel mid-divide: nothing written, unit back in IDLE.
      write_mt(1, 32'hAAAA_0000);
      write_mt(0, 32'h0000_5555);
      bus.in_valid = 1'b1;
      bus.div_ctrl = 2'b11;
      bus.src_a = 32'd12345;
      bus.src_b = 32'd7;
      repeat (10) @(posedge clk);
      #1;
      bus.cancel = 1'b1;
      #1;
      check("cancel_stall", bus.muldiv_stall, 0);
      check("cancel_busy_before", bus.busy, 1);
      @(posedge clk);
      #1;
      idle_inputs();
      check("cancel_idle", bus.busy, 0);
      check("cancel_hilo", {bus.hi, bus.lo}, {hi_m, lo_m});
      repeat (40) @(posedge clk);
      #1;
      check("cancel_hilo_late", {bus.hi, bus.lo}, {hi_m, lo_m});
      check("cancel_idle_late", bus.busy, 0);
      write_mt(1, 32'h1111_2222);
      check("mt_after_cancel", bus.hi, 32'h1111_2222);

      // Reset mid-divide clears everything at once.
      write_mt(1, 32'hAAAA_0000);
      write_mt(0, 32'h0000_5555);
      bus.in_valid = 1'b1;
      bus.div_ctrl = 2'b11;
      bus.src_a = 32'd999;
      bus.src_b = 32'd4;
      repeat (5) @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      check("rstmid_hilo", {bus.hi, bus.lo}, 64'd0);
      check("rstmid_busy", bus.busy, 0);
      check("rstmid_stall", bus.muldiv_stall, 0);
      idle_inputs();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      hi_m = 32'd0;
      lo_m = 32'd0;

      run_op(1, 1, 0, 32'd1000, 32'hFFFF_FFFD, 3, "held_done");
      run_op(0, 0, 0, 32'h0001_0000, 32'h0001_0000, 2, "held_mul");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
